// File: rtl/dblcdtx.sv
// Dual-scan LCD transmitter: fetches 4-bit nibbles from a framebuffer and drives
// the panel's lck/ld/llp/lflm timing, one GAP-DATA-LP sequence per line.
module dblcdtx #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int CLK_DIV  = 4,
  parameter int LP_WIDTH = 1,
  parameter int LINE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        fb_rd,
  output logic [31:0] fb_addr,
  input  logic [3:0]  fb_data,
  output logic        lflm,
  output logic        llp,
  output logic        lck,
  output logic [3:0]  ld,
  output logic        frame_done
);

  localparam int NIBS       = WIDTH / 4;
  localparam int HALF       = CLK_DIV / 2;
  localparam int GAP_CLKS   = LINE_GAP * CLK_DIV;
  localparam int LP_CLKS    = LP_WIDTH * CLK_DIV;
  localparam int FRAME_NIBS = NIBS * HEIGHT;
  localparam int MAX_A      = (GAP_CLKS > LP_CLKS) ? GAP_CLKS : LP_CLKS;
  localparam int MAX_CLKS   = (MAX_A > CLK_DIV) ? MAX_A : CLK_DIV;
  localparam int CNT_W      = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
  localparam int NIB_W      = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int LINE_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, GAP, DATA, LP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NIB_W-1:0]  nib_q, nib_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        ld_q, ld_d;
  logic              fb_rd_q, fb_rd_d;
  logic              lck_q, lck_d;
  logic              llp_q, llp_d;
  logic              lflm_q, lflm_d;
  logic              done_q, done_d;

  // Sequencing: cnt counts clks within the current GAP, lck period or LP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    nib_d   = nib_q;
    line_d  = line_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = GAP;
          line_d  = '0;
          nib_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CLKS - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
          nib_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (nib_q == NIB_W'(NIBS - 1)) begin
            state_d = LP;
            nib_d   = '0;
          end else begin
            nib_d = nib_q + NIB_W'(1);
          end
        end
      end
      LP: begin
        if (cnt_q == CNT_W'(LP_CLKS - 1)) begin
          cnt_d = '0;
          if (line_q == LINE_W'(HEIGHT - 1)) begin
            done_d  = 1'b1;
            line_d  = '0;
            state_d = en ? GAP : IDLE;
          end else begin
            line_d  = line_q + LINE_W'(1);
            state_d = GAP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so every port comes straight from a flop;
  // fb_rd leads each low phase by one clk so fb_data arrives on the low phase's first clk.
  always_comb begin
    lck_d   = (state_d == DATA) && (cnt_d >= CNT_W'(HALF));
    llp_d   = (state_d == LP);
    lflm_d  = (state_d == LP) && (line_d == LINE_W'(HEIGHT - 1));
    fb_rd_d = ((state_d == GAP) && (cnt_d == CNT_W'(GAP_CLKS - 1))) ||
              ((state_d == DATA) && (cnt_d == CNT_W'(CLK_DIV - 1)) &&
               (nib_d != NIB_W'(NIBS - 1)));

    if (state_q == IDLE)
      addr_d = '0;
    else if (fb_rd_q)
      addr_d = (addr_q == 32'(FRAME_NIBS - 1)) ? '0 : addr_q + 32'd1;
    else
      addr_d = addr_q;

    if (state_d == IDLE)
      ld_d = '0;
    else if ((state_q == DATA) && (cnt_q == '0))
      ld_d = fb_data;
    else
      ld_d = ld_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nib_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      ld_q    <= '0;
      fb_rd_q <= 1'b0;
      lck_q   <= 1'b0;
      llp_q   <= 1'b0;
      lflm_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      ld_q    <= ld_d;
      fb_rd_q <= fb_rd_d;
      lck_q   <= lck_d;
      llp_q   <= llp_d;
      lflm_q  <= lflm_d;
      done_q  <= done_d;
    end
  end

  assign fb_rd      = fb_rd_q;
  assign fb_addr    = addr_q;
  assign ld         = ld_q;
  assign lck        = lck_q;
  assign llp        = llp_q;
  assign lflm       = lflm_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_dblcdtx.sv
// Self-checking bench for dblcdtx at WIDTH=8, HEIGHT=2: 16-clk lines, 32-clk frames.
module tb_dblcdtx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fb_rd;
  logic [31:0] fb_addr;
  logic [3:0]  fb_data;
  logic        lflm, llp, lck, frame_done;
  logic [3:0]  ld;

  logic [3:0]  mem [4];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [3:0]  ld_prev = '0;

  always #5 clk = ~clk;

  dblcdtx #(.WIDTH(8), .HEIGHT(2), .CLK_DIV(4), .LP_WIDTH(1), .LINE_GAP(1)) dut (
    .clk(clk), .rst(rst), .en(en), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .fb_data(fb_data), .lflm(lflm), .llp(llp), .lck(lck), .ld(ld),
    .frame_done(frame_done)
  );

  // Framebuffer: data valid one clk after the read strobe.
  always @(posedge clk) begin
    if (rst) fb_data <= '0;
    else if (fb_rd) fb_data <= mem[fb_addr[1:0]];
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ld must be steady wherever lck is high.
  always @(negedge clk) begin
    if (lck === 1'b1) check("ld_stable", int'(ld), int'(ld_prev));
    ld_prev = ld;
  end

  task automatic chk_all_zero(input int fd);
    check("idle_fb_rd", int'(fb_rd), 0);
    check("idle_fb_addr", int'(fb_addr), 0);
    check("idle_lflm", int'(lflm), 0);
    check("idle_llp", int'(llp), 0);
    check("idle_lck", int'(lck), 0);
    check("idle_ld", int'(ld), 0);
    check("idle_frame_done", int'(frame_done), fd);
  endtask

  // Model: outputs as a function of the clk index within a frame.
  task automatic check_cycle(input int t, input logic [3:0] first_prev, input bit fd0);
    int ln = t / 16;
    int p  = t % 16;
    int k;
    int e_addr;
    int e_ld;
    k      = ln * 2 + int'(p >= 5) + int'(p >= 9);
    e_ld   = (k == 0) ? int'(first_prev) : int'(mem[k-1]);
    e_addr = (ln * 2 + int'(p >= 4) + int'(p >= 8)) % 4;
    check("lck", int'(lck), int'(p >= 4 && p < 12 && ((p - 4) % 4) >= 2));
    check("llp", int'(llp), int'(p >= 12));
    check("lflm", int'(lflm), int'(p >= 12 && ln == 1));
    check("fb_rd", int'(fb_rd), int'(p == 3 || p == 7));
    check("fb_addr", int'(fb_addr), e_addr);
    check("ld", int'(ld), e_ld);
    check("frame_done", int'(frame_done), int'(fd0 && t == 0));
  endtask

  task automatic run_frame(input logic [3:0] first_prev, input bit fd0,
                           input int drop_at, input int last_t);
    int   n_lck = 0, n_llp = 0, n_lflm = 0;
    logic pl = 1'b0, pp = 1'b0, pf = 1'b0;
    for (int t = 0; t <= last_t; t++) begin
      @(posedge clk); #1;
      check_cycle(t, first_prev, fd0);
      if (lck && !pl) n_lck++;
      if (llp && !pp) n_llp++;
      if (lflm && !pf) n_lflm++;
      pl = lck; pp = llp; pf = lflm;
      if (t == drop_at) en = 1'b0;
    end
    if (last_t == 31) begin
      check("lck_edges", n_lck, 4);
      check("llp_pulses", n_llp, 2);
      check("lflm_pulses", n_lflm, 1);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  typedef struct {
    int t; int lck; int llp; int lflm; int rd; int ld; int addr; int fd;
  } vec_t;
  vec_t tbl[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] prev;
    int         k;
    //                 t  lck llp lflm rd ld addr fd
    tbl.push_back('{ 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{ 3, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{ 4, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{ 5, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{ 6, 1, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{ 7, 1, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{ 8, 0, 0, 0, 0, 0, 2, 0});
    tbl.push_back('{ 9, 0, 0, 0, 0, 1, 2, 0});
    tbl.push_back('{10, 1, 0, 0, 0, 1, 2, 0});
    tbl.push_back('{11, 1, 0, 0, 0, 1, 2, 0});
    tbl.push_back('{12, 0, 1, 0, 0, 1, 2, 0});
    tbl.push_back('{15, 0, 1, 0, 0, 1, 2, 0});
    tbl.push_back('{16, 0, 0, 0, 0, 1, 2, 0});
    tbl.push_back('{19, 0, 0, 0, 1, 1, 2, 0});
    tbl.push_back('{21, 0, 0, 0, 0, 2, 3, 0});
    tbl.push_back('{23, 1, 0, 0, 1, 2, 3, 0});
    tbl.push_back('{25, 0, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{26, 1, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{28, 0, 1, 1, 0, 3, 0, 0});
    tbl.push_back('{31, 0, 1, 1, 0, 3, 0, 0});

    for (int i = 0; i < 4; i++) mem[i] = 4'(i);
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero(0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero(0);

    // First frame, fb_data = address.
    en = 1'b1;
    k  = 0;
    for (int t = 0; t < 32; t++) begin
      @(posedge clk); #1;
      if (k < tbl.size() && tbl[k].t == t) begin
        check("tv_lck", int'(lck), tbl[k].lck);
        check("tv_llp", int'(llp), tbl[k].llp);
        check("tv_lflm", int'(lflm), tbl[k].lflm);
        check("tv_fb_rd", int'(fb_rd), tbl[k].rd);
        check("tv_ld", int'(ld), tbl[k].ld);
        check("tv_fb_addr", int'(fb_addr), tbl[k].addr);
        check("tv_frame_done", int'(frame_done), tbl[k].fd);
        k++;
      end
    end
    check("tv_entries_used", k, tbl.size());

    // Three back-to-back random frames.
    for (int f = 0; f < 3; f++) begin
      prev = mem[3];
      randomize_mem();
      run_frame(prev, 1'b1, -1, 31);
    end

    // en dropped at clk 5: frame completes, then IDLE.
    prev = mem[3];
    randomize_mem();
    run_frame(prev, 1'b1, 5, 31);
    @(posedge clk); #1;
    chk_all_zero(1);
    repeat (2) begin
      @(posedge clk); #1;
      chk_all_zero(0);
    end

    // Reset mid-DATA, then restart from address 0.
    en = 1'b1;
    randomize_mem();
    run_frame(4'd0, 1'b0, -1, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero(0);
    @(posedge clk); #1;
    chk_all_zero(0);
    rst = 1'b0;
    randomize_mem();
    run_frame(4'd0, 1'b0, 5, 31);
    @(posedge clk); #1;
    chk_all_zero(1);
    @(posedge clk); #1;
    chk_all_zero(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dblcdtx.md
DBLCDTX -- requirements
Module: dblcdtx

Interface
REQ-001 Parameter WIDTH, default 320, pixels per line; multiple of 4.
REQ-002 Parameter HEIGHT, default 240, lines per frame.
REQ-003 Parameter CLK_DIV, default 4, clk cycles per lck period; even, >=2.
REQ-004 Parameter LP_WIDTH, default 1, llp pulse length in lck periods.
REQ-005 Parameter LINE_GAP, default 1, idle lck periods after each llp pulse.
REQ-006 Port clk  input  1: single system clock; all logic on posedge clk.
REQ-007 Port rst  input  1: reset, synchronous and active-high.
REQ-008 Port en  input  1: frame enable, sampled only in IDLE and at frame end.
REQ-009 Port fb_rd  output  1: framebuffer read strobe, one clk wide.
REQ-010 Port fb_addr  output  32: nibble address of the current read.
REQ-011 Port fb_data  input  4: read data, valid exactly 1 clk after fb_rd.
REQ-012 Port lflm  output  1: first-line marker.
REQ-013 Port llp  output  1: line latch pulse.
REQ-014 Port lck  output  1: pixel shift clock, 4 pixels per period.
REQ-015 Port ld  output  4: pixel data nibble.
REQ-016 Port frame_done  output  1: one-clk pulse at end of each frame.

Function
REQ-017 Block SHALL implement states IDLE, GAP, DATA, LP; all outputs registered.
REQ-018 IDLE: all outputs 0; on en=1, go to GAP with line=0, fb_addr=0.
REQ-019 Each lck period SHALL be CLK_DIV/2 clks low, then CLK_DIV/2 clks high; lck is 0 in every state except DATA.
REQ-020 DATA SHALL emit exactly WIDTH/4 lck periods per line, then enter LP.
REQ-021 ld SHALL load fb_data on the first clk of each DATA low phase and hold through the following high phase, so ld is stable at every lck rising edge.
REQ-022 fb_rd SHALL pulse exactly one clk before each DATA low phase begins, including the last clk of GAP before the first nibble of a line.
REQ-023 fb_addr SHALL increment by 1 on the clk after each fb_rd; after nibble WIDTH*HEIGHT/4-1 it SHALL wrap to 0.
REQ-024 LP: llp=1 for LP_WIDTH*CLK_DIV clks, lck=0; ld holds its last value.
REQ-025 lflm SHALL equal llp during the LP of line HEIGHT-1, and 0 at all other times.
REQ-026 GAP SHALL last LINE_GAP*CLK_DIV clks with llp=0 and lck=0, then enter DATA.
REQ-027 After LP of line HEIGHT-1, frame_done SHALL pulse for 1 clk on LP exit, and line SHALL reset to 0.
REQ-028 At frame end, if en=1 go to GAP for the next frame; else go to IDLE with ld=0.
REQ-029 Deassertion of en mid-frame SHALL NOT truncate the frame.
REQ-030 The line counter SHALL be clog2(HEIGHT) bits wide and the nibble counter clog2(WIDTH/4) bits wide; neither SHALL overflow.

Reset
REQ-031 rst=1 SHALL force IDLE on the next clk, from any state, mid-line included.
REQ-032 After reset: lflm=0, llp=0, lck=0, ld=0, fb_rd=0, fb_addr=0, frame_done=0, line=0, nibble=0.
REQ-033 rst SHALL take priority over en.

Verification
Settings: WIDTH=8, HEIGHT=2, CLK_DIV=4, LP_WIDTH=1, LINE_GAP=1. Each line is 4 GAP + 8 DATA + 4 LP clks = 16 clks; each frame is 32 clks.
REQ-034 Reset, then en=1 with fb_data=addr[3:0] -> fb_rd at clks 3 and 7 after the GAP start; ld=0 then 1 on the lck rising edges; llp high on clks 12-15; lflm=0 in line 0.
REQ-035 Continue into line 1 -> ld=2 then 3; lflm=llp=1 for 4 clks; frame_done pulses once at clk 32; fb_addr wraps to 0.
REQ-036 Hold en=1 for 3 frames -> frame_done exactly every 32 clks; exactly 4 lck rising edges, 2 llp pulses and 1 lflm pulse per frame.
REQ-037 Drop en at clk 5 of a frame -> the frame completes normally; IDLE afterwards with all outputs 0.
REQ-038 Assert rst during DATA (clk 9) -> on the next clk all outputs 0 and state IDLE; with en=1, the next frame restarts at fb_addr 0.
REQ-039 Check ld stability -> ld never changes on a clk where lck=1.
